matmul_ctrl_nxn: RTL and testbench
==================================

Name: matmul_ctrl_nxn

Overview:
- Parametrised successor to the 2x2 matrix-multiply controller: computes C = A x B (or C += A x B) for NxN operand matrices.
- Operands load through a valid/ready port, are computed with an internal sequential MAC, and results stream out with valid/ready backpressure.
- Sits between the host I/O shim and the result path; it replaces the fixed 2x2 load/compute/output FSM.

Parameters:
- N, 2, matrix dimension (N >= 2).
- DW, 8, operand element width.
- ACC_W, 2*DW+$clog2(N), accumulator and result width.
- SIGNED, 0, 1 = two's-complement operands and products; 0 = unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- load_valid  in  1  operand element valid
- load_ready  out  1  block accepts operands (high only in IDLE)
- load_sel_ab  in  1  0 = A, 1 = B
- load_index  in  $clog2(N*N)  row-major element index (row*N+col)
- in_data  in  DW  operand element
- start  in  1  begin computation (sampled in IDLE)
- acc_mode  in  1  sampled with start; 1 = add to existing C
- busy  out  1  high in COMPUTE and OUTPUT
- done  out  1  one-cycle pulse when all of C is written
- out_valid  out  1  result element valid
- out_ready  in  1  host accepts result element
- out_data  out  ACC_W  C element, row-major order
- out_index  out  $clog2(N*N)  index of out_data
- out_last  out  1  high with the final element (index N*N-1)

Behaviour:
- Reset (rst_n low at clk edge):
  - State goes to IDLE.
  - A, B and C storage cleared to 0; a_loaded and b_loaded bitmaps cleared.
  - Outputs: load_ready=1 (IDLE), busy=0, done=0, out_valid=0, out_data=0, out_index=0, out_last=0.
  - Reset mid-COMPUTE or mid-OUTPUT aborts immediately; no done pulse.
- States: IDLE, COMPUTE, OUTPUT.
- Loading: an element is written on load_valid && load_ready and sets its bit in a_loaded or b_loaded. Rewriting an element overwrites it. Bitmaps persist across runs, so operands are reusable.
- IDLE -> COMPUTE: on start when every bit of both bitmaps (registered value) is set.
  - start with incomplete operands is ignored.
  - A load and start in the same cycle: the load is written, but start is judged on the pre-load bitmaps.
  - acc_mode is latched at start.
- COMPUTE:
  - Counters i, j, k in nested order: k innermost, then j, then i.
  - One MAC per cycle: acc += A[i][k]*B[k][j].
  - On k==N-1, C[i][j] <= (acc_mode_q ? C[i][j] : 0) + acc + product, and acc clears.
  - Arithmetic is modulo 2^ACC_W; wrap, no saturation. Products are sign-extended when SIGNED=1.
  - Exactly N^3 cycles. done pulses in the cycle after the last C write, coincident with entry to OUTPUT.
  - start is ignored while busy.
- OUTPUT:
  - out_valid=1; out_data=C[out_index], starting at out_index=0.
  - out_index advances on out_valid && out_ready. out_data and out_index hold while out_ready=0.
  - The handshake with out_last=1 returns to IDLE in the next cycle, with out_valid=0.
  - C is retained after the run for later accumulation.
- out_data=0 whenever out_valid=0.

Decomposition:
- Package matmul_pkg: state enum (IDLE, COMPUTE, OUTPUT) and the index-width helper function.
- One sub-module, mac_unit (multiply plus accumulate, signed/unsigned by parameter), instantiated once.
- Operand/result storage, counters and FSM stay in matmul_ctrl_nxn.

Test Plan:
- N=2, DW=8: load A=[1 2;3 4], B=[5 6;7 8], start, acc_mode=0.
  - Required: done exactly 8 cycles after start.
  - Stream 19, 22, 43, 50 with out_index 0..3; out_last on 50.
- Repeat start with acc_mode=1 and no reload -> stream 38, 44, 86, 100.
- Load only 7 of 8 elements, then start -> stays IDLE, busy=0. Load the eighth, start -> computes.
- All operands 255 -> each C = 130050 (17 bits, no wrap). Hold out_ready low 5 cycles -> out_data/out_index stable; each element delivered exactly once.
- Assert rst_n low at cycle 3 of COMPUTE -> next cycle IDLE, no done, bitmaps 0, and start is ignored until reload.
- SIGNED=1: A=[-1 2;3 -4], B=[5 -6;7 8] -> 9, 22, -13, -50 (ACC_W two's complement).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the NxN matrix-multiply controller.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Width of a row-major element index into an n x n matrix.
  function automatic int idx_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matmul_ctrl_nxn_if.sv
// Host-side load / control / result-stream bundle for matmul_ctrl_nxn.
interface matmul_ctrl_nxn_if
  import matmul_pkg::*;
#(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 2 * DW + $clog2(N)
);
  localparam int IW = idx_w(N);

  logic             load_valid;
  logic             load_ready;
  logic             load_sel_ab;
  logic [IW-1:0]    load_index;
  logic [DW-1:0]    in_data;
  logic             start;
  logic             acc_mode;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [IW-1:0]    out_index;
  logic             out_last;

  modport master (
    output load_valid, load_sel_ab, load_index, in_data, start, acc_mode, out_ready,
    input  load_ready, busy, done, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  load_valid, load_sel_ab, load_index, in_data, start, acc_mode, out_ready,
    output load_ready, busy, done, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/matmul_ctrl_nxn_mac_unit.sv
// Single multiply-accumulate step: acc_out = acc_in + a*b, modulo 2^ACC_W.
module mac_unit #(
  parameter int DW     = 8,
  parameter int ACC_W  = 17,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);

  logic signed [2*DW-1:0] prod_s;
  logic        [2*DW-1:0] prod_u;
  logic        [ACC_W-1:0] prod_ext;

  // Form the product in the selected number system, extend it to the accumulator width and add.
  always_comb begin
    prod_s   = $signed(a) * $signed(b);
    prod_u   = a * b;
    prod_ext = SIGNED ? ACC_W'(prod_s) : ACC_W'(prod_u);
    acc_out  = acc_in + prod_ext;
  end

endmodule

// File: rtl/matmul_ctrl_nxn.sv
// NxN matrix-multiply controller: operand load, sequential MAC compute, streamed result.
module matmul_ctrl_nxn
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int ACC_W  = 2 * DW + $clog2(N),
  parameter bit SIGNED = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  matmul_ctrl_nxn_if.slave bus
);

  localparam int NN = N * N;
  localparam int IW = idx_w(N);
  localparam int CW = $clog2(N);

  state_e state, state_nxt;

  logic [DW-1:0]    a_mem [NN];
  logic [DW-1:0]    b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];
  logic [NN-1:0]    a_loaded;
  logic [NN-1:0]    b_loaded;

  logic [CW-1:0]    ci;
  logic [CW-1:0]    cj;
  logic [CW-1:0]    ck;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mac_sum;
  logic             acc_mode_q;
  logic             done_q;
  logic [IW-1:0]    out_idx;

  logic             load_fire;
  logic             start_ok;
  logic             out_fire;
  logic             i_last;
  logic             j_last;
  logic             k_last;
  logic             last_mac;
  logic [IW-1:0]    a_idx;
  logic [IW-1:0]    b_idx;
  logic [IW-1:0]    c_idx;

  function automatic logic [IW-1:0] flat(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return IW'(int'(r) * N + int'(c));
  endfunction

  assign load_fire = bus.load_valid && (state == IDLE);
  assign start_ok  = bus.start && (state == IDLE) && (&a_loaded) && (&b_loaded);
  assign out_fire  = (state == OUTPUT) && bus.out_ready;
  assign i_last    = (ci == CW'(N - 1));
  assign j_last    = (cj == CW'(N - 1));
  assign k_last    = (ck == CW'(N - 1));
  assign last_mac  = (state == COMPUTE) && i_last && j_last && k_last;
  assign a_idx     = flat(ci, ck);
  assign b_idx     = flat(ck, cj);
  assign c_idx     = flat(ci, cj);

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mac (
    .a      (a_mem[a_idx]),
    .b      (b_mem[b_idx]),
    .acc_in (acc),
    .acc_out(mac_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start needs complete operands, compute runs N^3 cycles, output ends on the last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = COMPUTE;
      COMPUTE: if (last_mac) state_nxt = OUTPUT;
      OUTPUT:  if (out_fire && bus.out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; result data is forced to zero outside OUTPUT.
  always_comb begin
    bus.load_ready = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.done       = done_q;
    bus.out_valid  = (state == OUTPUT);
    bus.out_index  = out_idx;
    bus.out_last   = (state == OUTPUT) && (int'(out_idx) == NN - 1);
    bus.out_data   = (state == OUTPUT) ? c_mem[out_idx] : '0;
  end

  // Operand storage and loaded bitmaps; these persist across runs so operands can be reused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
      end
      a_loaded <= '0;
      b_loaded <= '0;
    end else if (load_fire && (int'(bus.load_index) < NN)) begin
      if (bus.load_sel_ab) begin
        b_mem[bus.load_index]    <= bus.in_data;
        b_loaded[bus.load_index] <= 1'b1;
      end else begin
        a_mem[bus.load_index]    <= bus.in_data;
        a_loaded[bus.load_index] <= 1'b1;
      end
    end
  end

  // i/j/k walk with k innermost; each completed dot product lands in C, optionally on top of the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ci         <= '0;
      cj         <= '0;
      ck         <= '0;
      acc        <= '0;
      acc_mode_q <= 1'b0;
      for (int n = 0; n < NN; n++) c_mem[n] <= '0;
    end else if (start_ok) begin
      ci         <= '0;
      cj         <= '0;
      ck         <= '0;
      acc        <= '0;
      acc_mode_q <= bus.acc_mode;
    end else if (state == COMPUTE) begin
      if (k_last) begin
        c_mem[c_idx] <= (acc_mode_q ? c_mem[c_idx] : '0) + mac_sum;
        acc          <= '0;
        ck           <= '0;
        if (j_last) begin
          cj <= '0;
          ci <= i_last ? '0 : ci + 1'b1;
        end else begin
          cj <= cj + 1'b1;
        end
      end else begin
        acc <= mac_sum;
        ck  <= ck + 1'b1;
      end
    end
  end

  // done follows the final C write by one cycle; the result pointer steps on each accepted element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      out_idx <= '0;
    end else begin
      done_q <= last_mac;
      if (out_fire) out_idx <= bus.out_last ? '0 : out_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_ctrl_nxn.sv
// Scoreboard bench for matmul_ctrl_nxn: unsigned instance (dut0) and signed instance (dut1), N=2, DW=8.
module tb_matmul_ctrl_nxn;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 17;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [1:0]       idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  matmul_ctrl_nxn_if #(.N(N), .DW(DW), .ACC_W(ACC_W)) bus0 ();
  matmul_ctrl_nxn_if #(.N(N), .DW(DW), .ACC_W(ACC_W)) bus1 ();

  matmul_ctrl_nxn #(.N(N), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n0),
    .bus  (bus0)
  );

  matmul_ctrl_nxn #(.N(N), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n1),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic scoreOut(input int d, input logic [ACC_W-1:0] data, input logic [1:0] idx, input logic last);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL dut%0d unexpected output: got idx %0d data %0d, required no output", d, idx, data);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput($sformatf("dut%0d out_data[%0d]", d, e.idx), longint'(data), longint'(e.data));
      checkOutput($sformatf("dut%0d out_index", d), longint'(idx), longint'(e.idx));
      checkOutput($sformatf("dut%0d out_last[%0d]", d, e.idx), longint'(last), longint'(e.last));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n0 && bus0.out_valid && bus0.out_ready)
      scoreOut(0, bus0.out_data, bus0.out_index, bus0.out_last);
  end

  always @(negedge clk) begin
    if (rst_n1 && bus1.out_valid && bus1.out_ready)
      scoreOut(1, bus1.out_data, bus1.out_index, bus1.out_last);
  end

  task automatic expectStream(input int d, input int v0, input int v1, input int v2, input int v3);
    int v[4];
    v = '{v0, v1, v2, v3};
    for (int n = 0; n < 4; n++) begin
      exp_t e;
      e.data = ACC_W'(v[n]);
      e.idx  = 2'(n);
      e.last = (n == 3);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int d, input logic sel, input int idx, input logic [DW-1:0] val);
    if (d == 0) begin
      bus0.load_valid = 1'b1; bus0.load_sel_ab = sel; bus0.load_index = 2'(idx); bus0.in_data = val;
    end else begin
      bus1.load_valid = 1'b1; bus1.load_sel_ab = sel; bus1.load_index = 2'(idx); bus1.in_data = val;
    end
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    bus1.load_valid = 1'b0;
  endtask

  task automatic loadAB(input int d,
                        input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input logic [DW-1:0] a2, input logic [DW-1:0] a3,
                        input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                        input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    applyStimulus(d, 1'b0, 0, a0); applyStimulus(d, 1'b0, 1, a1);
    applyStimulus(d, 1'b0, 2, a2); applyStimulus(d, 1'b0, 3, a3);
    applyStimulus(d, 1'b1, 0, b0); applyStimulus(d, 1'b1, 1, b1);
    applyStimulus(d, 1'b1, 2, b2); applyStimulus(d, 1'b1, 3, b3);
  endtask

  task automatic startRun(input int d, input logic mode);
    if (d == 0) begin bus0.start = 1'b1; bus0.acc_mode = mode; end
    else        begin bus1.start = 1'b1; bus1.acc_mode = mode; end
    @(posedge clk); #1;
    bus0.start = 1'b0; bus0.acc_mode = 1'b0;
    bus1.start = 1'b0; bus1.acc_mode = 1'b0;
  endtask

  task automatic waitDone(input int d, input int lat);
    int cyc = 0;
    logic seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      seen = (d == 0) ? bus0.done : bus1.done;
    end
    checkOutput($sformatf("dut%0d done latency", d), seen ? cyc : -1, lat);
    @(posedge clk); #1;
    checkOutput($sformatf("dut%0d done single pulse", d), (d == 0) ? bus0.done : bus1.done, 0);
  endtask

  task automatic waitIdle(input int d);
    int cyc = 0;
    while (((d == 0) ? bus0.busy : bus1.busy) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput($sformatf("dut%0d back to idle", d), (d == 0) ? bus0.busy : bus1.busy, 0);
  endtask

  task automatic resetDut(input int d);
    if (d == 0) rst_n0 = 1'b0; else rst_n1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    if (d == 0) rst_n0 = 1'b1; else rst_n1 = 1'b1;
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    bus0.load_valid = 1'b0; bus0.load_sel_ab = 1'b0; bus0.load_index = '0; bus0.in_data = '0;
    bus0.start = 1'b0; bus0.acc_mode = 1'b0; bus0.out_ready = 1'b1;
    bus1.load_valid = 1'b0; bus1.load_sel_ab = 1'b0; bus1.load_index = '0; bus1.in_data = '0;
    bus1.start = 1'b0; bus1.acc_mode = 1'b0; bus1.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    checkOutput("reset load_ready", bus0.load_ready, 1);
    checkOutput("reset busy", bus0.busy, 0);
    checkOutput("reset done", bus0.done, 0);
    checkOutput("reset out_valid", bus0.out_valid, 0);
    checkOutput("reset out_data", bus0.out_data, 0);
    checkOutput("reset out_index", bus0.out_index, 0);
    checkOutput("reset out_last", bus0.out_last, 0);

    $display("[TB] basic 2x2 product");
    loadAB(0, 1, 2, 3, 4, 5, 6, 7, 8);
    expectStream(0, 19, 22, 43, 50);
    startRun(0, 1'b0);
    checkOutput("busy after start", bus0.busy, 1);
    waitDone(0, 8);
    waitIdle(0);

    $display("[TB] accumulate without reload");
    expectStream(0, 38, 44, 86, 100);
    startRun(0, 1'b1);
    waitDone(0, 8);
    waitIdle(0);

    $display("[TB] start with incomplete operands");
    resetDut(0);
    applyStimulus(0, 1'b0, 0, 1); applyStimulus(0, 1'b0, 1, 2);
    applyStimulus(0, 1'b0, 2, 3); applyStimulus(0, 1'b0, 3, 4);
    applyStimulus(0, 1'b1, 0, 5); applyStimulus(0, 1'b1, 1, 6);
    applyStimulus(0, 1'b1, 2, 7);
    startRun(0, 1'b0);
    checkOutput("incomplete start busy", bus0.busy, 0);
    checkOutput("incomplete start load_ready", bus0.load_ready, 1);
    @(posedge clk); #1;
    checkOutput("incomplete start still idle", bus0.busy, 0);
    applyStimulus(0, 1'b1, 3, 8);
    expectStream(0, 19, 22, 43, 50);
    startRun(0, 1'b0);
    waitDone(0, 8);
    waitIdle(0);

    $display("[TB] all-255 operands with backpressure");
    loadAB(0, 255, 255, 255, 255, 255, 255, 255, 255);
    bus0.out_ready = 1'b0;
    expectStream(0, 130050, 130050, 130050, 130050);
    startRun(0, 1'b0);
    waitDone(0, 8);
    for (int n = 0; n < 5; n++) begin
      checkOutput("stall out_valid", bus0.out_valid, 1);
      checkOutput("stall out_data", bus0.out_data, 130050);
      checkOutput("stall out_index", bus0.out_index, 0);
      @(posedge clk); #1;
    end
    bus0.out_ready = 1'b1;
    waitIdle(0);

    $display("[TB] reset during compute");
    startRun(0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid-compute reset busy", bus0.busy, 0);
    checkOutput("mid-compute reset done", bus0.done, 0);
    checkOutput("mid-compute reset load_ready", bus0.load_ready, 1);
    rst_n0 = 1'b1;
    startRun(0, 1'b0);
    checkOutput("start after reset ignored", bus0.busy, 0);
    checkOutput("no done after reset", bus0.done, 0);
    loadAB(0, 1, 2, 3, 4, 5, 6, 7, 8);
    expectStream(0, 19, 22, 43, 50);
    startRun(0, 1'b1);
    waitDone(0, 8);
    waitIdle(0);

    $display("[TB] signed operands");
    loadAB(1, 8'hFF, 8'd2, 8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'd8);
    expectStream(1, 9, 22, -13, -50);
    startRun(1, 1'b0);
    waitDone(1, 8);
    waitIdle(1);

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("dut0 expected outputs consumed", q0.size(), 0);
    checkOutput("dut1 expected outputs consumed", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
